// File: rtl/main_memory_controller_pkg.sv
// Shared widths, state encodings and request payload for the cache-to-memory block responder.
package main_memory_controller_pkg;

  localparam int unsigned ADRES_BIT   = 32;
  localparam int unsigned VERI_BIT    = 32;
  localparam int unsigned BLOK_BIT    = 128;
  localparam int unsigned BEAT_SAYISI = BLOK_BIT / VERI_BIT;
  localparam int unsigned SAYAC_BIT   = $clog2(BEAT_SAYISI) + 1;

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] OKU   = 2'd1;
  localparam logic [1:0] YAZ   = 2'd2;
  localparam logic [1:0] DONUS = 2'd3;

  localparam logic [ADRES_BIT-1:0] ADRES_MASKE = ~ADRES_BIT'(BLOK_BIT / 8 - 1);

  typedef struct packed {
    logic [ADRES_BIT-1:0] taban;
    logic                 veri_istemci;
  } istek_t;

  // Word address of a beat within a block-aligned base.
  function automatic logic [ADRES_BIT-1:0] beat_adres(input logic [ADRES_BIT-1:0] taban,
                                                      input logic [SAYAC_BIT-1:0] beat);
    return taban + (ADRES_BIT'(beat) << 2);
  endfunction

endpackage

// File: rtl/main_memory_controller_block_word_assembler.sv
// Collects in-order read words into the lanes of one cache block.
module main_memory_controller_block_word_assembler
  import main_memory_controller_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_temizle,
  input  logic                i_yaz_en,
  input  logic [VERI_BIT-1:0] i_kelime,
  output logic [BLOK_BIT-1:0] o_blok_sonraki_c,
  output logic                o_son_c
);

  logic [SAYAC_BIT-1:0] r_sayac;
  logic [BLOK_BIT-1:0]  r_blok;

  // Block as it looks once the word arriving now is placed in its lane.
  always_comb begin
    o_blok_sonraki_c = r_blok;
    for (int unsigned i = 0; i < BEAT_SAYISI; i++) begin
      if (i_yaz_en && (r_sayac == SAYAC_BIT'(i))) begin
        o_blok_sonraki_c[i*VERI_BIT +: VERI_BIT] = i_kelime;
      end
    end
    o_son_c = i_yaz_en && (r_sayac == SAYAC_BIT'(BEAT_SAYISI - 1));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sayac <= '0;
      r_blok  <= '0;
    end else if (i_temizle) begin
      r_sayac <= '0;
      r_blok  <= '0;
    end else if (i_yaz_en && (r_sayac < SAYAC_BIT'(BEAT_SAYISI))) begin
      r_sayac <= r_sayac + SAYAC_BIT'(1);
      r_blok  <= o_blok_sonraki_c;
    end
  end

endmodule

// File: rtl/main_memory_controller.sv
// Serves instruction/data cache block requests as four word transactions to main memory.
module main_memory_controller
  import main_memory_controller_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADRES_BIT-1:0] b_okuma_istek_adres_i,
  input  logic                 b_okuma_istek_gecerli_i,
  output logic [BLOK_BIT-1:0]  b_okuma_veri_blok_o,
  output logic                 b_okuma_istek_hazir_o,
  input  logic [ADRES_BIT-1:0] v_istek_adres_i,
  input  logic                 v_istek_gecerli_i,
  input  logic                 v_istek_yaz_i,
  input  logic [BLOK_BIT-1:0]  v_yazma_veri_blok_i,
  output logic [BLOK_BIT-1:0]  v_okuma_veri_blok_o,
  output logic                 v_istek_hazir_o,
  output logic [ADRES_BIT-1:0] bellek_istek_adres_o,
  output logic                 bellek_istek_gecerli_o,
  output logic                 bellek_istek_yaz_o,
  output logic [VERI_BIT-1:0]  bellek_yazma_veri_o,
  input  logic                 bellek_istek_kabul_i,
  input  logic [VERI_BIT-1:0]  bellek_okuma_veri_i,
  input  logic                 bellek_okuma_gecerli_i
);

  logic [1:0]           r_durum, w_durum_d;
  istek_t               r_istek, w_istek_d;
  logic                 r_rr_veri, w_rr_d;
  logic [SAYAC_BIT-1:0] r_gonder, w_gonder_d;
  logic [BLOK_BIT-1:0]  r_yazma_blok, w_yazma_blok_d;

  logic                 w_kabul, w_sec_veri, w_yaz_sec, w_aktif_d, w_tamam;
  logic                 w_okuma_en, w_temizle, w_son_c;
  logic [BLOK_BIT-1:0]  w_blok_sonraki;
  logic [ADRES_BIT-1:0] w_bellek_adres_d;
  logic [VERI_BIT-1:0]  w_bellek_veri_d;
  logic                 w_bellek_yaz_d;

  assign w_temizle  = (r_durum == BOSTA);
  assign w_okuma_en = (r_durum == OKU) && bellek_okuma_gecerli_i;

  main_memory_controller_block_word_assembler u_assembler (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .i_temizle        (w_temizle),
    .i_yaz_en         (w_okuma_en),
    .i_kelime         (bellek_okuma_veri_i),
    .o_blok_sonraki_c (w_blok_sonraki),
    .o_son_c          (w_son_c)
  );

  // Arbitration, beat sequencing and next values of the registered memory-side outputs.
  always_comb begin
    w_durum_d      = r_durum;
    w_istek_d      = r_istek;
    w_rr_d         = r_rr_veri;
    w_gonder_d     = r_gonder;
    w_yazma_blok_d = r_yazma_blok;
    w_sec_veri     = 1'b0;
    w_yaz_sec      = 1'b0;
    w_kabul        = bellek_istek_gecerli_o && bellek_istek_kabul_i;

    case (r_durum)
      BOSTA: begin
        w_gonder_d = '0;
        if (v_istek_gecerli_i || b_okuma_istek_gecerli_i) begin
          w_sec_veri = v_istek_gecerli_i && (!b_okuma_istek_gecerli_i || r_rr_veri);
          w_yaz_sec  = w_sec_veri && v_istek_yaz_i;
          if (v_istek_gecerli_i && b_okuma_istek_gecerli_i) w_rr_d = ~r_rr_veri;
          w_istek_d.taban = (w_sec_veri ? v_istek_adres_i : b_okuma_istek_adres_i) & ADRES_MASKE;
          w_istek_d.veri_istemci = w_sec_veri;
          if (w_yaz_sec) w_yazma_blok_d = v_yazma_veri_blok_i;
          w_durum_d = w_yaz_sec ? YAZ : OKU;
        end
      end
      OKU: begin
        if (w_kabul) w_gonder_d = r_gonder + SAYAC_BIT'(1);
        if (w_son_c) w_durum_d = DONUS;
      end
      YAZ: begin
        if (w_kabul) begin
          w_gonder_d = r_gonder + SAYAC_BIT'(1);
          if (r_gonder == SAYAC_BIT'(BEAT_SAYISI - 1)) w_durum_d = DONUS;
        end
      end
      DONUS:   w_durum_d = BOSTA;
      default: w_durum_d = BOSTA;
    endcase

    w_aktif_d        = ((r_durum == OKU) || (r_durum == YAZ)) &&
                       (w_gonder_d < SAYAC_BIT'(BEAT_SAYISI));
    w_bellek_yaz_d   = w_aktif_d && (r_durum == YAZ);
    w_bellek_adres_d = w_aktif_d ? beat_adres(r_istek.taban, w_gonder_d) : '0;
    w_bellek_veri_d  = '0;
    for (int unsigned i = 0; i < BEAT_SAYISI; i++) begin
      if (w_bellek_yaz_d && (w_gonder_d == SAYAC_BIT'(i))) begin
        w_bellek_veri_d = r_yazma_blok[i*VERI_BIT +: VERI_BIT];
      end
    end
    w_tamam = (w_durum_d == DONUS) && (r_durum != DONUS);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_durum <= BOSTA;
    end else begin
      r_durum <= w_durum_d;
    end
  end

  // Request context, pointers and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_istek                <= '0;
      r_rr_veri              <= 1'b1;
      r_gonder               <= '0;
      r_yazma_blok           <= '0;
      bellek_istek_gecerli_o <= 1'b0;
      bellek_istek_yaz_o     <= 1'b0;
      bellek_istek_adres_o   <= '0;
      bellek_yazma_veri_o    <= '0;
      b_okuma_istek_hazir_o  <= 1'b0;
      v_istek_hazir_o        <= 1'b0;
      b_okuma_veri_blok_o    <= '0;
      v_okuma_veri_blok_o    <= '0;
    end else begin
      r_istek                <= w_istek_d;
      r_rr_veri              <= w_rr_d;
      r_gonder               <= w_gonder_d;
      r_yazma_blok           <= w_yazma_blok_d;
      bellek_istek_gecerli_o <= w_aktif_d;
      bellek_istek_yaz_o     <= w_bellek_yaz_d;
      bellek_istek_adres_o   <= w_bellek_adres_d;
      bellek_yazma_veri_o    <= w_bellek_veri_d;
      b_okuma_istek_hazir_o  <= w_tamam && !r_istek.veri_istemci;
      v_istek_hazir_o        <= w_tamam && r_istek.veri_istemci;
      if (w_son_c) begin
        if (r_istek.veri_istemci) v_okuma_veri_blok_o <= w_blok_sonraki;
        else                      b_okuma_veri_blok_o <= w_blok_sonraki;
      end
    end
  end

endmodule
